// File: rtl/jtmitchell_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtmitchell_pkg
//  Description : Shared constants for the Mitchell I/O block: Z80 port
//                addresses, 93Cxx serial EEPROM opcodes and FSM state enum.
//  Revision    : 1.0  initial release
// ============================================================================
package jtmitchell_pkg;

    // Z80 I/O port addresses (A[4:0])
    localparam logic [4:0] c_PORT_MISC   = 5'h00;
    localparam logic [4:0] c_PORT_CAB1   = 5'h01;
    localparam logic [4:0] c_PORT_BANK   = 5'h02;
    localparam logic [4:0] c_PORT_SYS    = 5'h03;
    localparam logic [4:0] c_PORT_PCM    = 5'h05;
    localparam logic [4:0] c_PORT_DMA    = 5'h06;
    localparam logic [4:0] c_PORT_VRAM   = 5'h07;
    localparam logic [4:0] c_PORT_EE_CS  = 5'h08;
    localparam logic [4:0] c_PORT_EE_CLK = 5'h10;
    localparam logic [4:0] c_PORT_EE_DI  = 5'h18;

    // 93Cxx opcodes (two bits following the start bit)
    localparam logic [1:0] c_OP_EXT   = 2'b00;
    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_READ  = 2'b10;
    localparam logic [1:0] c_OP_ERASE = 2'b11;

    typedef enum logic [2:0] {
        EE_IDLE   = 3'd0,
        EE_START  = 3'd1,
        EE_OPC    = 3'd2,
        EE_ADDR   = 3'd3,
        EE_RDOUT  = 3'd4,
        EE_WRDATA = 3'd5,
        EE_BUSY   = 3'd6
    } ee_state_t;

endpackage
`default_nettype wire

// File: rtl/jtmitchell_eeprom93c.sv
`default_nettype none
// ============================================================================
//  Module      : jtmitchell_eeprom93c
//  Description : 93C46/93C56-style 16-bit serial EEPROM model. Bit events
//                happen on the rising edge of the serial clock input. A byte
//                wide side port allows NVRAM dump/restore.
//  Revision    : 1.0  initial release
// ============================================================================
module jtmitchell_eeprom93c
    import jtmitchell_pkg::*;
#(
    parameter int EE_AW    = 6,
    parameter int BUSY_CYC = 64
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen_i,
    input  logic             cs_i,
    input  logic             sclk_i,
    input  logic             di_i,
    output logic             do_o,
    input  logic [EE_AW:0]   prog_addr_i,
    input  logic [7:0]       prog_data_i,
    input  logic             prog_we_i,
    output logic [7:0]       prog_din_o
);

    localparam int         c_DEPTH     = 1 << EE_AW;
    localparam int         c_BW        = $clog2(BUSY_CYC + 1);
    localparam logic [4:0] c_AW_LAST   = 5'(EE_AW - 1);
    localparam logic [4:0] c_AW_DONE   = 5'(EE_AW);
    localparam logic [4:0] c_WORD_LAST = 5'd15;
    localparam logic [4:0] c_WORD_DONE = 5'd16;
    localparam logic [c_BW-1:0] c_BUSY_LAST = c_BW'(BUSY_CYC - 1);

    ee_state_t           state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [EE_AW-1:0]    addr_q, addr_d;
    logic [15:0]         data_q, data_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [c_BW-1:0]     busy_q, busy_d;
    logic                do_q, do_d;
    logic                wp_q, wp_d;
    logic                sclk_q;

    logic [15:0]         mem_q [0:c_DEPTH-1];

    logic                w_edge;
    logic                w_mem_we;
    logic [15:0]         w_mem_wdata;
    logic [15:0]         w_rd_word;
    logic [15:0]         w_prog_word;

    assign w_edge      = sclk_i & ~sclk_q;
    assign w_rd_word   = mem_q[addr_q];
    assign w_prog_word = mem_q[prog_addr_i[EE_AW:1]];
    assign prog_din_o  = prog_addr_i[0] ? w_prog_word[15:8] : w_prog_word[7:0];
    assign do_o        = do_q;

    // Serial protocol: next state, shift registers and storage write request
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        do_d        = do_q;
        wp_d        = wp_q;
        w_mem_we    = 1'b0;
        w_mem_wdata = data_q;

        case (state_q)
            EE_IDLE: begin
                if (cs_i) state_d = EE_START;
            end
            EE_START: begin
                if (!cs_i) begin
                    state_d = EE_IDLE;
                end else if (w_edge && di_i) begin
                    state_d = EE_OPC;
                    cnt_d   = 5'd0;
                end
            end
            EE_OPC: begin
                if (!cs_i) begin
                    state_d = EE_IDLE;
                end else if (w_edge) begin
                    op_d = {op_q[0], di_i};
                    if (cnt_q == 5'd1) begin
                        state_d = EE_ADDR;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            EE_ADDR: begin
                if (!cs_i) begin
                    // Only a fully addressed ERASE commits on deselect
                    if (cnt_q == c_AW_DONE && op_q == c_OP_ERASE) begin
                        w_mem_we    = ~wp_q;
                        w_mem_wdata = 16'hFFFF;
                        state_d     = EE_BUSY;
                        busy_d      = '0;
                        do_d        = 1'b0;
                    end else begin
                        state_d = EE_IDLE;
                    end
                end else if (w_edge && cnt_q != c_AW_DONE) begin
                    addr_d = {addr_q[EE_AW-2:0], di_i};
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == c_AW_LAST) begin
                        case (op_q)
                            c_OP_READ: begin
                                state_d = EE_RDOUT;
                                cnt_d   = 5'd0;
                                do_d    = 1'b0;   // dummy zero before data
                            end
                            c_OP_WRITE: begin
                                state_d = EE_WRDATA;
                                cnt_d   = 5'd0;
                            end
                            c_OP_EXT: begin
                                if (addr_d[EE_AW-1 -: 2] == 2'b11)
                                    wp_d = 1'b0;  // EWEN
                                else if (addr_d[EE_AW-1 -: 2] == 2'b00)
                                    wp_d = 1'b1;  // EWDS
                            end
                            default: ;             // ERASE waits for deselect
                        endcase
                    end
                end
            end
            EE_RDOUT: begin
                if (!cs_i) begin
                    state_d = EE_IDLE;
                end else if (w_edge) begin
                    do_d = w_rd_word[4'd15 - cnt_q[3:0]];
                    if (cnt_q == c_WORD_LAST) begin
                        cnt_d  = 5'd0;
                        addr_d = addr_q + 1'b1;    // sequential read wraps
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            EE_WRDATA: begin
                if (!cs_i) begin
                    if (cnt_q == c_WORD_DONE) begin
                        w_mem_we = ~wp_q;
                        state_d  = EE_BUSY;
                        busy_d   = '0;
                        do_d     = 1'b0;
                    end else begin
                        state_d = EE_IDLE;         // partial word dropped
                    end
                end else if (w_edge && cnt_q != c_WORD_DONE) begin
                    data_d = {data_q[14:0], di_i};
                    cnt_d  = cnt_q + 5'd1;
                end
            end
            EE_BUSY: begin
                do_d = 1'b0;
                if (cen_i) begin
                    if (busy_q == c_BUSY_LAST) state_d = EE_IDLE;
                    else                       busy_d  = busy_q + 1'b1;
                end
            end
            default: state_d = EE_IDLE;
        endcase

        // Ready is signalled whenever the device is idle
        if (state_d == EE_IDLE) do_d = 1'b1;
    end

    // Protocol registers; reset aborts any command in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EE_IDLE;
            op_q    <= 2'b00;
            addr_q  <= '0;
            data_q  <= 16'h0000;
            cnt_q   <= 5'd0;
            busy_q  <= '0;
            do_q    <= 1'b1;
            wp_q    <= 1'b1;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            do_q    <= do_d;
            wp_q    <= wp_d;
            sclk_q  <= sclk_i;
        end
    end

    // Storage is non-volatile: never reset; the side port wins a collision
    always_ff @(posedge clk) begin
        if (prog_we_i) begin
            if (prog_addr_i[0]) mem_q[prog_addr_i[EE_AW:1]][15:8] <= prog_data_i;
            else                mem_q[prog_addr_i[EE_AW:1]][7:0]  <= prog_data_i;
        end else if (w_mem_we) begin
            mem_q[addr_q] <= w_mem_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtmitchell_io.sv
`default_nettype none
// ============================================================================
//  Module      : jtmitchell_io
//  Description : Mitchell board Z80 I/O decoder: cabinet inputs, ROM bank,
//                misc latch, chip selects and serial EEPROM bit-bang port.
//                Define JTMITCHELL_EEPROM_EN to include the EEPROM model.
//  Revision    : 1.0  initial release
// ============================================================================
module jtmitchell_io
    import jtmitchell_pkg::*;
#(
    parameter int BANKW    = 4,
    parameter int EE_AW    = 6,
    parameter int BUSY_CYC = 64
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             iorq_n,
    input  logic             rd_n,
    input  logic             wr_n,
    input  logic [4:0]       addr,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             rd_hit,
    input  logic [7:0]       cab0,
    input  logic [7:0]       cab1,
    input  logic [7:0]       cab2,
    input  logic             vblank,
    output logic [BANKW-1:0] bank,
    output logic [7:0]       misc,
    output logic             vram_msb,
    output logic             dma_go,
    output logic             fm_cs,
    output logic             pcm_cs,
    input  logic [EE_AW:0]   prog_addr,
    input  logic [7:0]       prog_data,
    input  logic             prog_we,
    output logic [7:0]       prog_din
);

    logic [BANKW-1:0] bank_q, bank_d;
    logic [7:0]       misc_q, misc_d;
    logic             vram_q, vram_d;
    logic [7:0]       dout_q, dout_d;
    logic             rd_hit_q, rd_hit_d;

    logic             w_wr;
    logic             w_rd;
    logic             w_ee_do;
    logic [7:0]       w_sys;

    assign w_wr  = cen & ~iorq_n & ~wr_n;
    assign w_rd  = ~iorq_n & ~rd_n;
    assign w_sys = {w_ee_do, 3'b111, vblank, 3'b111};

    // Chip selects follow the bus directly
    assign fm_cs  = ~iorq_n & (addr == c_PORT_BANK || addr == c_PORT_SYS);
    assign pcm_cs = ~iorq_n & (addr == c_PORT_PCM);
    assign dma_go = ~iorq_n & (addr == c_PORT_DMA);

    assign bank     = bank_q;
    assign misc     = misc_q;
    assign vram_msb = vram_q;
    assign dout     = dout_q;
    assign rd_hit   = rd_hit_q;

    // Write latches and read mux next-state
    always_comb begin
        bank_d   = bank_q;
        misc_d   = misc_q;
        vram_d   = vram_q;
        dout_d   = 8'hFF;
        rd_hit_d = 1'b0;
        if (w_wr) begin
            case (addr)
                c_PORT_MISC: misc_d = din;
                c_PORT_BANK: bank_d = din[BANKW-1:0];
                c_PORT_VRAM: vram_d = din[0];
                default: ;
            endcase
        end
        if (w_rd) begin
            case (addr)
                5'h00: begin dout_d = cab0;  rd_hit_d = 1'b1; end
                5'h01: begin dout_d = cab1;  rd_hit_d = 1'b1; end
                5'h02: begin dout_d = cab2;  rd_hit_d = 1'b1; end
                5'h03: begin dout_d = w_sys; rd_hit_d = 1'b1; end
                default: ;
            endcase
        end
    end

    // CPU-visible registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q   <= '0;
            misc_q   <= 8'h00;
            vram_q   <= 1'b0;
            dout_q   <= 8'hFF;
            rd_hit_q <= 1'b0;
        end else begin
            bank_q   <= bank_d;
            misc_q   <= misc_d;
            vram_q   <= vram_d;
            dout_q   <= dout_d;
            rd_hit_q <= rd_hit_d;
        end
    end

`ifdef JTMITCHELL_EEPROM_EN
    logic ee_cs_q, ee_clk_q, ee_di_q;

    // EEPROM bit-bang lines, one port per line, value from din[0]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ee_cs_q  <= 1'b0;
            ee_clk_q <= 1'b0;
            ee_di_q  <= 1'b0;
        end else if (w_wr) begin
            if (addr == c_PORT_EE_CS)  ee_cs_q  <= din[0];
            if (addr == c_PORT_EE_CLK) ee_clk_q <= din[0];
            if (addr == c_PORT_EE_DI)  ee_di_q  <= din[0];
        end
    end

    jtmitchell_eeprom93c #(
        .EE_AW    (EE_AW),
        .BUSY_CYC (BUSY_CYC)
    ) u_eeprom (
        .clk         (clk),
        .rst_n       (rst_n),
        .cen_i       (cen),
        .cs_i        (ee_cs_q),
        .sclk_i      (ee_clk_q),
        .di_i        (ee_di_q),
        .do_o        (w_ee_do),
        .prog_addr_i (prog_addr),
        .prog_data_i (prog_data),
        .prog_we_i   (prog_we),
        .prog_din_o  (prog_din)
    );
`else
    // No EEPROM fitted: the data line floats high and the dump port is blank
    logic w_unused_prog;
    assign w_unused_prog = &{1'b0, prog_addr, prog_data, prog_we};
    assign w_ee_do       = 1'b1;
    assign prog_din      = 8'hFF;
`endif

endmodule
`default_nettype wire
